// File: rtl/inst_encoder_pkg.sv
// Package shared by the instruction encoder slice.
// Holds the opcode-group and function constants, the session FSM state enum,
// the bit-field positions of the packed 32-bit instruction word, and helper
// functions for packing fields and judging {op,fn} legality.
package inst_encoder_pkg;

   // Opcode groups (bits [31:28] of the packed word)
   localparam logic [3:0] OP_BR   = 4'b0010;
   localparam logic [3:0] OP_SW   = 4'b0011;
   localparam logic [3:0] OP_ALUI = 4'b0100;
   localparam logic [3:0] OP_CMPI = 4'b0101;
   localparam logic [3:0] OP_JAL  = 4'b0110;
   localparam logic [3:0] OP_LW   = 4'b0111;
   localparam logic [3:0] OP_ALUR = 4'b1100;
   localparam logic [3:0] OP_CMPR = 4'b1101;

   // Function-code constants and legal-fn sets, one bit per fn value
   localparam logic [3:0]  FN_ZERO      = 4'h0;
   localparam logic [3:0]  FN_EXT       = 4'hF;
   localparam logic [15:0] FN_SET_ALU   = 16'h07C7;  // {0,1,2,6,7,8,9,A}
   localparam logic [15:0] FN_SET_ALUI  = 16'h87C7;  // ALU set plus F
   localparam logic [15:0] FN_SET_CMP   = 16'h9669;  // {0,3,5,6,9,A,C,F}
   localparam logic [15:0] FN_SET_ZERO  = 16'h0001;  // fn 0 only
   localparam logic [15:0] FN_SET_BR    = 16'hFF6F;  // all except 4 and 7
   localparam logic [15:0] FN_SET_NONE  = 16'h0000;

   // Bit-field positions within the packed word
   localparam int OP_MSB  = 31;
   localparam int OP_LSB  = 28;
   localparam int FN_MSB  = 27;
   localparam int FN_LSB  = 24;
   localparam int F1_MSB  = 23;
   localparam int F1_LSB  = 20;
   localparam int F2_MSB  = 19;
   localparam int F2_LSB  = 16;
   localparam int F3_MSB  = 15;
   localparam int F3_LSB  = 12;
   localparam int IMM_MSB = 15;
   localparam int IMM_LSB = 0;

   // Session FSM states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Pack decoded fields into a 32-bit word; unknown groups carry op/fn only
   function automatic logic [31:0] pack_inst(
      input logic [3:0]  op,
      input logic [3:0]  fn,
      input logic [3:0]  rd,
      input logic [3:0]  rs1,
      input logic [3:0]  rs2,
      input logic [15:0] imm
   );
      logic [31:0] w;
      w = 32'h0000_0000;
      w[OP_MSB:OP_LSB] = op;
      w[FN_MSB:FN_LSB] = fn;
      case (op)
         OP_ALUR, OP_CMPR: begin
            w[F1_MSB:F1_LSB] = rd;
            w[F2_MSB:F2_LSB] = rs1;
            w[F3_MSB:F3_LSB] = rs2;
         end
         OP_ALUI, OP_CMPI, OP_LW, OP_JAL: begin
            w[F1_MSB:F1_LSB]   = rd;
            w[F2_MSB:F2_LSB]   = rs1;
            w[IMM_MSB:IMM_LSB] = imm;
         end
         OP_BR: begin
            w[F1_MSB:F1_LSB]   = rs1;
            w[F2_MSB:F2_LSB]   = rs2;
            w[IMM_MSB:IMM_LSB] = imm;
         end
         OP_SW: begin
            // store puts the data register (rs2) in the first field
            w[F1_MSB:F1_LSB]   = rs2;
            w[F2_MSB:F2_LSB]   = rs1;
            w[IMM_MSB:IMM_LSB] = imm;
         end
         default: begin
            w[F1_MSB:IMM_LSB] = 24'h00_0000;
         end
      endcase
      return w;
   endfunction

   // True when the {op,fn} pair names a defined instruction
   function automatic logic fn_legal(input logic [3:0] op, input logic [3:0] fn);
      logic [15:0] set;
      case (op)
         OP_ALUR:               set = FN_SET_ALU;
         OP_ALUI:               set = FN_SET_ALUI;
         OP_CMPR, OP_CMPI:      set = FN_SET_CMP;
         OP_LW, OP_SW, OP_JAL:  set = FN_SET_ZERO;
         OP_BR:                 set = FN_SET_BR;
         default:               set = FN_SET_NONE;
      endcase
      return set[fn];
   endfunction

endpackage

// File: rtl/inst_encoder_fifo.sv
// enc_fifo: synchronous packed-word buffer between the field-input side and
// the instruction-memory write port.
// Ports: clk, reset (sync active-high, empties the buffer), push/din write
// side, pop/dout read side (dout shows the head entry), full/empty flags.
// DEPTH must be a power of 2, at least 2.
module enc_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PW-1:0]    wr_ptr_r;
   logic [PW-1:0]    rd_ptr_r;
   logic [CW-1:0]    count_r;
   logic             do_push_s;
   logic             do_pop_s;

   // Guard the strobes so an overflow or underflow can never corrupt state
   always_comb begin
      do_push_s = push && !full;
      do_pop_s  = pop && !empty;
   end

   // Flags and head-of-queue data
   always_comb begin
      full  = (count_r == CW'(DEPTH));
      empty = (count_r == CW'(0));
      dout  = mem_r[rd_ptr_r];
   end

   // Storage array; contents are don't-care while the entry is unoccupied
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_r[wr_ptr_r] <= din;
      end
   end

   // Pointers and occupancy; a simultaneous push and pop leaves count unchanged
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_r <= PW'(0);
         rd_ptr_r <= PW'(0);
         count_r  <= CW'(0);
      end else begin
         if (do_push_s) begin
            wr_ptr_r <= wr_ptr_r + PW'(1);
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + PW'(1);
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/inst_encoder.sv
// inst_encoder: packs instruction fields into 32-bit words, buffers them and
// writes them to consecutive instruction-memory addresses starting at
// base_addr for one load session (start ... in_last).
// Ports: clk, reset (sync active-high); start/base_addr begin a session;
// in_valid/in_ready/in_last and in_op/in_fn/in_rd/in_rs1/in_rs2/in_imm field
// input; imem_wr_en/imem_addr/imem_wdata with imem_ready memory write port;
// busy, done (one-cycle pulse), err (sticky illegal), wrap (sticky address
// wrap), wr_count (words written this session).
// Build option: define ENCODER_LEGALITY_CHECK_EN to drop illegal {op,fn}
// transfers and flag them on err; by default every transfer is written.
module inst_encoder
   import inst_encoder_pkg::*;
#(
   parameter int INST_BIT_WIDTH = 32,
   parameter int ADDR_WIDTH     = 10,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic [ADDR_WIDTH-1:0]     base_addr,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic                      in_last,
   input  logic [3:0]                in_op,
   input  logic [3:0]                in_fn,
   input  logic [3:0]                in_rd,
   input  logic [3:0]                in_rs1,
   input  logic [3:0]                in_rs2,
   input  logic [15:0]               in_imm,
   output logic                      imem_wr_en,
   output logic [ADDR_WIDTH-1:0]     imem_addr,
   output logic [INST_BIT_WIDTH-1:0] imem_wdata,
   input  logic                      imem_ready,
   output logic                      busy,
   output logic                      done,
   output logic                      err,
   output logic                      wrap,
   output logic [ADDR_WIDTH:0]       wr_count
);

   state_t                    state_r;
   state_t                    state_next_s;
   logic [ADDR_WIDTH-1:0]     addr_r;
   logic [ADDR_WIDTH:0]       count_r;
   logic                      err_r;
   logic                      wrap_r;
   logic                      full_s;
   logic                      empty_s;
   logic                      accept_s;
   logic                      push_s;
   logic                      pop_s;
   logic                      err_set_s;
   logic                      session_start_s;
   logic [INST_BIT_WIDTH-1:0] word_s;
   logic [INST_BIT_WIDTH-1:0] head_s;

   // Handshake, push/pop strobes and the optional legality filter
   always_comb begin
      in_ready        = (state_r == RUN) && !full_s;
      accept_s        = in_valid && in_ready;
      pop_s           = !empty_s && imem_ready;
      session_start_s = (state_r == IDLE) && start;
      word_s          = INST_BIT_WIDTH'(pack_inst(in_op, in_fn, in_rd, in_rs1, in_rs2, in_imm));
`ifdef ENCODER_LEGALITY_CHECK_EN
      push_s    = accept_s && fn_legal(in_op, in_fn);
      err_set_s = accept_s && !fn_legal(in_op, in_fn);
`else
      push_s    = accept_s;
      err_set_s = 1'b0;
`endif
   end

   enc_fifo #(
      .WIDTH (INST_BIT_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push_s),
      .din   (word_s),
      .pop   (pop_s),
      .dout  (head_s),
      .full  (full_s),
      .empty (empty_s)
   );

   // Session FSM state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Session FSM next-state; an illegal last transfer still ends the session
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) state_next_s = RUN;
            else       state_next_s = IDLE;
         end
         RUN: begin
            if (accept_s && in_last) state_next_s = DRAIN;
            else                     state_next_s = RUN;
         end
         DRAIN: begin
            if (empty_s) state_next_s = DONE;
            else         state_next_s = DRAIN;
         end
         DONE:    state_next_s = IDLE;
         default: state_next_s = IDLE;
      endcase
   end

   // Write address, word counter and sticky flags
   always_ff @(posedge clk) begin
      if (reset) begin
         addr_r  <= '0;
         count_r <= '0;
         err_r   <= 1'b0;
         wrap_r  <= 1'b0;
      end else if (session_start_s) begin
         addr_r  <= base_addr;
         count_r <= '0;
         err_r   <= 1'b0;
         wrap_r  <= 1'b0;
      end else begin
         if (pop_s) begin
            addr_r  <= addr_r + ADDR_WIDTH'(1);
            count_r <= count_r + (ADDR_WIDTH+1)'(1);
            if (addr_r == {ADDR_WIDTH{1'b1}}) begin
               wrap_r <= 1'b1;
            end
         end
         if (err_set_s) begin
            err_r <= 1'b1;
         end
      end
   end

   // Output port mapping; write data reads as zero whenever nothing is buffered
   always_comb begin
      imem_wr_en = !empty_s;
      imem_addr  = addr_r;
      imem_wdata = empty_s ? '0 : head_s;
      busy       = (state_r == RUN) || (state_r == DRAIN);
      done       = (state_r == DONE);
      err        = err_r;
      wrap       = wrap_r;
      wr_count   = count_r;
   end

endmodule

// File: tb/tb_inst_encoder.sv
module tb_inst_encoder;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [9:0]  base_addr;
   logic        in_valid;
   logic        in_ready;
   logic        in_last;
   logic [3:0]  in_op, in_fn, in_rd, in_rs1, in_rs2;
   logic [15:0] in_imm;
   logic        imem_wr_en;
   logic [9:0]  imem_addr;
   logic [31:0] imem_wdata;
   logic        imem_ready;
   logic        busy, done, err, wrap;
   logic [10:0] wr_count;

   int          chk_cnt  = 0;
   int          pass_cnt = 0;
   int          writes_seen = 0;
   logic [41:0] sb_q[$];        // {addr, data}
   logic [9:0]  exp_addr;

   always #5 clk = ~clk;

   inst_encoder dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .base_addr  (base_addr),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_last    (in_last),
      .in_op      (in_op),
      .in_fn      (in_fn),
      .in_rd      (in_rd),
      .in_rs1     (in_rs1),
      .in_rs2     (in_rs2),
      .in_imm     (in_imm),
      .imem_wr_en (imem_wr_en),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .imem_ready (imem_ready),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .wrap       (wrap),
      .wr_count   (wr_count)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      chk_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Independent reference encoding, written from the format table
   function automatic logic [31:0] ref_word(input logic [3:0] op, fn, rd, rs1, rs2,
                                            input logic [15:0] imm);
      case (op)
         4'hC, 4'hD:             return {op, fn, rd, rs1, rs2, 12'h000};
         4'h4, 4'h5, 4'h7, 4'h6: return {op, fn, rd, rs1, imm};
         4'h2:                   return {op, fn, rs1, rs2, imm};
         4'h3:                   return {op, fn, rs2, rs1, imm};
         default:                return {op, fn, 24'h000000};
      endcase
   endfunction

   function automatic bit ref_legal(input logic [3:0] op, fn);
      case (op)
         4'hC:             return fn inside {4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA};
         4'h4:             return fn inside {4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hF};
         4'hD, 4'h5:       return fn inside {4'h0, 4'h3, 4'h5, 4'h6, 4'h9, 4'hA, 4'hC, 4'hF};
         4'h7, 4'h3, 4'h6: return fn == 4'h0;
         4'h2:             return !(fn inside {4'h4, 4'h7});
         default:          return 1'b0;
      endcase
   endfunction

   function automatic bit will_write(input logic [3:0] op, fn);
`ifdef ENCODER_LEGALITY_CHECK_EN
      return ref_legal(op, fn);
`else
      return 1'b1;
`endif
   endfunction

   // Write-port monitor: every accepted memory write must match the scoreboard head
   always @(negedge clk) begin
      logic [41:0] e;
      if (!reset && imem_wr_en && imem_ready) begin
         writes_seen++;
         if (sb_q.size() == 0) begin
            check("unexpected_write", {22'h0, imem_addr, imem_wdata}, 64'h0);
         end else begin
            e = sb_q.pop_front();
            check("wr_addr", 64'(imem_addr), 64'(e[41:32]));
            check("wr_data", 64'(imem_wdata), 64'(e[31:0]));
         end
      end
   end

   task automatic begin_session(input logic [9:0] base);
      @(posedge clk); #1;
      start = 1'b1; base_addr = base;
      exp_addr = base;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic send(input logic [3:0] op, fn, rd, rs1, rs2,
                       input logic [15:0] imm, input logic last);
      int n = 0;
      in_valid = 1'b1; in_op = op; in_fn = fn; in_rd = rd;
      in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_last = last;
      while (!in_ready && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      check("in_ready_wait", 64'(in_ready), 64'd1);
      if (will_write(op, fn)) begin
         sb_q.push_back({exp_addr, ref_word(op, fn, rd, rs1, rs2, imm)});
         exp_addr = exp_addr + 10'd1;
      end
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic wait_done(input int exp_cnt, input logic exp_err, input logic exp_wrap);
      int n = 0;
      @(negedge clk);
      while (!done && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("done_pulse", 64'(done), 64'd1);
      check("wr_count", 64'(wr_count), 64'(exp_cnt));
      check("err", 64'(err), 64'(exp_err));
      check("wrap", 64'(wrap), 64'(exp_wrap));
      check("sb_empty", 64'(sb_q.size()), 64'd0);
      @(negedge clk);
      check("done_one_cycle", {62'h0, done, busy}, 64'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check(tag, {in_ready, imem_wr_en, imem_addr, imem_wdata, wr_count, busy, done, err, wrap}, 64'd0);
   endtask

   initial begin
      int w0;
      logic exp_e;
      reset = 1'b1; start = 1'b0; base_addr = 10'h000; in_valid = 1'b0; in_last = 1'b0;
      in_op = 4'h0; in_fn = 4'h0; in_rd = 4'h0; in_rs1 = 4'h0; in_rs2 = 4'h0;
      in_imm = 16'h0000; imem_ready = 1'b1; exp_addr = 10'h000;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_all_zero("reset_state");
      @(posedge clk); #1;
      reset = 1'b0;

      // Single R-format word
      begin_session(10'h010);
      check("busy_in_run", 64'(busy), 64'd1);
      send(4'hC, 4'h7, 4'h3, 4'h1, 4'h2, 16'h0ABC, 1'b1);
      wait_done(1, 1'b0, 1'b0);

      // Mixed formats; a start pulse mid-session must be ignored
      begin_session(10'h020);
      send(4'h2, 4'h3, 4'h9, 4'h5, 4'h6, 16'hFFFC, 1'b0);
      start = 1'b1; base_addr = 10'h200;
      @(posedge clk); #1;
      start = 1'b0;
      send(4'h3, 4'h0, 4'hE, 4'h5, 4'h6, 16'h1234, 1'b0);
      send(4'h4, 4'hF, 4'h1, 4'h2, 4'h7, 16'h00FF, 1'b0);
      send(4'hD, 4'h3, 4'hA, 4'hB, 4'hC, 16'h5555, 1'b0);
      send(4'h6, 4'h0, 4'hF, 4'h8, 4'h1, 16'h8001, 1'b1);
      wait_done(5, 1'b0, 1'b0);

      // Back-pressure: buffer fills after 4 accepts, then drains in order
      imem_ready = 1'b0;
      begin_session(10'h100);
      for (int i = 0; i < 4; i++) begin
         send(4'h5, 4'h9, 4'(i), 4'(i + 1), 4'h0, 16'(16'h1000 + i), 1'b0);
      end
      check("full_in_ready", 64'(in_ready), 64'd0);
      check("stall_wr_en", 64'(imem_wr_en), 64'd1);
      check("stall_count", 64'(wr_count), 64'd0);
      imem_ready = 1'b1;
      send(4'h7, 4'h0, 4'h4, 4'h3, 4'h0, 16'hBEEF, 1'b1);
      wait_done(5, 1'b0, 1'b0);

      // Address wrap at the top of memory
      begin_session(10'h3FF);
      send(4'hC, 4'h1, 4'h1, 4'h2, 4'h3, 16'h0000, 1'b0);
      send(4'hC, 4'h2, 4'h4, 4'h5, 4'h6, 16'h0000, 1'b1);
      wait_done(2, 1'b0, 1'b1);

      // Undefined op group; flags from the last session must clear on start
      begin_session(10'h040);
      send(4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000, 1'b1);
      exp_e = !will_write(4'hF, 4'h0);
      wait_done(exp_e ? 0 : 1, exp_e, 1'b0);

      // Reset while draining discards buffered words
      imem_ready = 1'b0;
      begin_session(10'h050);
      send(4'hC, 4'h0, 4'h1, 4'h1, 4'h1, 16'h0000, 1'b0);
      send(4'hC, 4'h6, 4'h2, 4'h2, 4'h2, 16'h0000, 1'b1);
      @(negedge clk);
      check("drain_busy", {62'h0, busy, imem_wr_en}, 64'd3);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      sb_q.delete();
      imem_ready = 1'b1;
      w0 = writes_seen;
      repeat (10) @(negedge clk);
      check("no_writes_after_reset", 64'(writes_seen - w0), 64'd0);
      check_all_zero("post_reset_state");

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/inst_encoder.md
INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 SHALL have parameters: INST_BIT_WIDTH, default 32, instruction word width; ADDR_WIDTH, default 10, instruction-memory word address width; FIFO_DEPTH, default 4, number of packed-word buffer entries (power of 2).
REQ-002 SHALL use one clock; reset is synchronous and active-high. Ports: clk  in  1  rising-edge clock.
REQ-003 reset  in  1  synchronous active-high reset.
REQ-004 start  in  1  one-cycle pulse; begins a load session at base_addr.
REQ-005 base_addr  in  ADDR_WIDTH  first write address, sampled on start.
REQ-006 in_valid / in_ready  in / out  1  field-input handshake; transfer when both are high.
REQ-007 in_last  in  1  marks the final instruction of a session.
REQ-008 in_op, in_fn, in_rd, in_rs1, in_rs2  in  4 each  opcode group, function, destination, source 1, source 2.
REQ-009 in_imm  in  16  immediate.
REQ-010 imem_wr_en, imem_addr, imem_wdata  out  1 / ADDR_WIDTH / INST_BIT_WIDTH  instruction-memory write port.
REQ-011 imem_ready  in  1  memory accepts a write this cycle.
REQ-012 busy, done, err, wrap  out  1 each  session active; one-cycle completion pulse; sticky illegal-instruction flag; sticky address-wrap flag.
REQ-013 wr_count  out  ADDR_WIDTH+1  words written this session.

Function
REQ-014 SHALL pack bits [31:28]=in_op and [27:24]=in_fn for all formats.
REQ-015 op 1100/1101 (ALU-R, CMP-R): [23:20]=rd, [19:16]=rs1, [15:12]=rs2, [11:0]=0.
REQ-016 op 0100/0101/0111/0110 (ALU-I, CMP-I, LW, JAL): [23:20]=rd, [19:16]=rs1, [15:0]=imm.
REQ-017 op 0010 (branch): [23:20]=rs1, [19:16]=rs2, [15:0]=imm; op 0011 (SW): [23:20]=rs2, [19:16]=rs1, [15:0]=imm.
REQ-018 SHALL use FSM states IDLE, RUN, DRAIN, DONE: IDLE->RUN on start; RUN->DRAIN on an accepted transfer with in_last=1; DRAIN->DONE when FIFO empty and no write pending; DONE->IDLE after one cycle.
REQ-019 in_ready = (state==RUN) && FIFO not full; start is ignored outside IDLE.
REQ-020 An accepted word SHALL enter the FIFO at the clock edge and appear on imem_wdata no earlier than the next cycle.
REQ-021 imem_wr_en = FIFO not empty; on imem_wr_en && imem_ready: pop, increment imem_addr, increment wr_count.
REQ-022 A simultaneous push and pop SHALL leave occupancy unchanged; push when full is impossible (in_ready low).
REQ-023 imem_addr SHALL wrap from 2^ADDR_WIDTH-1 to 0 and set wrap.
REQ-024 done SHALL pulse one cycle in DONE; busy = state in {RUN, DRAIN}.
REQ-025 On start: imem_addr=base_addr, wr_count=0, err=0, wrap=0.

Reset
REQ-026 Reset SHALL force state IDLE, empty FIFO, in_ready=0, imem_wr_en=0, imem_addr=0, imem_wdata=0, wr_count=0, busy=0, done=0, err=0, wrap=0.
REQ-027 Reset mid-session SHALL discard buffered words with no further writes.

Configuration
REQ-028 With ENCODER_LEGALITY_CHECK_EN defined: an illegal {op,fn} transfer is accepted but not buffered, err is set, and wr_count is unaffected. Legal pairs: 1100 fn in {0,1,2,6,7,8,9,A}; 0100 fn in that set plus F; 1101/0101 fn in {0,3,5,6,9,A,C,F}; 0111/0011/0110 fn 0; 0010 any fn except 4 and 7.
REQ-029 Without ENCODER_LEGALITY_CHECK_EN: every transfer is packed and written, and err stays 0.

Structure
REQ-030 A shared package SHALL hold opcode-group constants, fn constants, the FSM state enum, and bit-field position constants.
REQ-031 The buffer SHALL be a sub-module, enc_fifo (synchronous, FIFO_DEPTH entries, full/empty flags).

Verification
REQ-032 base=0x010, op=C fn=7 rd=3 rs1=1 rs2=2, last -> write 0xC7312000 @0x010, done pulse, wr_count=1.
REQ-033 op=2 fn=3 rs1=5 rs2=6 imm=0xFFFC -> imem_wdata=0x2356FFFC.
REQ-034 imem_ready=0 with 5 valid inputs -> in_ready low after 4 accepts; release -> 5 ordered writes.
REQ-035 base=0x3FF, two words -> writes @0x3FF then @0x000, wrap=1.
REQ-036 op=F fn=0 with macro -> err=1, no write; without macro -> write 0xF0...; reset in DRAIN -> no writes, all outputs 0.
